decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameters SHALL be:
- DW, 32, data/register width.
- NREG, 32, register count.
- AW, $clog2(NREG), register address width.
- IW, 16, immediate width (IW<=DW).
- JW, 26, jump field width.
- PW, 4, upper PC bits; jump target width is PW+JW+2.

REQ-002 Ports SHALL be:
- reloj  in  1  clock; all state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  decode request present.
- in_ready  out  1  stage can accept a request.
- DIR_A, DIR_B  in  AW  read addresses.
- DIR_WRA  in  AW  write address.
- DI  in  DW  write data.
- REG_RD  in  1  active-low read enable.
- REG_WR  in  1  active-low write enable.
- SEL_I  in  1  1 = sign-extend, 0 = zero-extend.
- IMD  in  IW  immediate.
- address  in  JW  jump field.
- pc_4  in  PW  upper PC bits.
- flush  in  1  kill the output stage.
- out_valid  out  1  output holds a valid decode.
- out_ready  in  1  consumer accepts the output.
- DOA, DOB  out  DW  operands.
- out_mux_sz  out  DW  extended immediate.
- out_addr  out  PW+JW+2  jump target.

REQ-003 One clock and one reset SHALL be used: clock reloj; reset resetn, asynchronous, active-low.

Function
REQ-004 The register file SHALL hold NREG entries of DW bits. Register 0 SHALL read as zero, and writes to it SHALL be ignored.

REQ-005 A write SHALL occur on a rising edge when REG_WR==0 and DIR_WRA!=0. Writes are independent of the handshake, stall and flush.

REQ-006 Read value for a port, evaluated combinationally at the capture edge:
- REG_RD==1 -> 0.
- Otherwise, if the port address equals DIR_WRA, REG_WR==0 and the address is not 0 -> DI (write-through bypass).
- Otherwise -> stored entry.

REQ-007 Extended immediate:
- SEL_I==1 -> IMD sign-extended to DW.
- SEL_I==0 -> IMD zero-extended to DW.

REQ-008 Jump target SHALL be {pc_4, address, 2'b00}.

REQ-009 DOA, DOB, out_mux_sz and out_addr SHALL be registered outputs with one-cycle latency from capture.

REQ-010 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.

REQ-011 Capture SHALL occur when in_valid && in_ready on a rising edge. On capture, all four data outputs load and out_valid becomes 1.

REQ-012 Output-stage states SHALL be EMPTY (out_valid=0) and FULL (out_valid=1), with these transitions:
- EMPTY -> FULL on capture.
- FULL -> FULL on capture with out_ready=1 (back-to-back, no bubble).
- FULL -> EMPTY on out_ready=1 with no capture.
- FULL holds with out_ready=0.

REQ-013 While FULL and out_ready==0, all data outputs SHALL hold stable. Register-file writes to the captured addresses SHALL NOT alter the held DOA/DOB.

REQ-014 flush==1 SHALL force out_valid to 0 at the next edge and block capture in that cycle. Data outputs may retain stale values.

REQ-015 When in_valid and flush are asserted together, flush SHALL win and the request SHALL NOT be captured.

REQ-016 When DIR_A==DIR_B, both ports SHALL return the identical value, bypass included.

Reset
REQ-017 On resetn==0, immediately and independently of reloj:
- out_valid=0.
- DOA=DOB=out_mux_sz=out_addr=0.
- All register-file entries = 0.

REQ-018 Release of resetn SHALL take effect at the first rising edge with resetn==1. No capture or write occurs while resetn==0.

REQ-019 Reset asserted mid-operation SHALL discard any held output and all register contents. in_ready SHALL be 1 in the first cycle after release, provided flush==0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF to r5; next cycle read A=5, B=0, REG_RD=0, in_valid=1 -> after 1 edge out_valid=1, DOA=0xDEADBEEF, DOB=0.
- Same-cycle write r7=0x12345678 and read A=7, B=7 -> DOA=DOB=0x12345678. Write to r0 plus read A=0 -> DOA=0.
- IMD=0x8001: SEL_I=1 -> out_mux_sz=0xFFFF8001; SEL_I=0 -> 0x00008001. pc_4=0xA, address=0x3FFFFFF -> out_addr=0xAFFFFFFC.
- out_ready=0 for 3 cycles while FULL, in_valid=1, r5 rewritten -> in_ready=0, outputs unchanged. out_ready=1 -> next request captured on that edge with no bubble.
- flush=1 with in_valid=1 while FULL -> out_valid=0 next edge, no capture. REG_RD=1 capture -> DOA=DOB=0.
- resetn pulsed low asynchronously mid-stall -> out_valid and outputs 0 immediately. Read r5 after release -> 0.

Source files
------------

// File: rtl/decode_pipe.sv
// Decode stage: register file with write-through bypass, immediate extension,
// jump target formation and a single-entry valid/ready output register.
module decode_pipe #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int IW   = 16,
  parameter int JW   = 26,
  parameter int PW   = 4
) (
  input  logic                reloj,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       DIR_A,
  input  logic [AW-1:0]       DIR_B,
  input  logic [AW-1:0]       DIR_WRA,
  input  logic [DW-1:0]       DI,
  input  logic                REG_RD,
  input  logic                REG_WR,
  input  logic                SEL_I,
  input  logic [IW-1:0]       IMD,
  input  logic [JW-1:0]       address,
  input  logic [PW-1:0]       pc_4,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       DOA,
  output logic [DW-1:0]       DOB,
  output logic [DW-1:0]       out_mux_sz,
  output logic [PW+JW+1:0]    out_addr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  stage_state_t state_q, state_d;

  logic [DW-1:0]      regs_q [NREG];
  logic [DW-1:0]      doa_q, dob_q, imm_q;
  logic [PW+JW+1:0]   jmp_q;

  logic               rfWrEn;
  logic               capture;
  logic [DW-1:0]      readA, readB;
  logic [DW-1:0]      extImm;
  logic [PW+JW+1:0]   jmpTarget;

  // Read one port: disabled reads give zero, r0 is hardwired to zero, and a
  // same-cycle write to the addressed entry is forwarded straight from DI.
  function automatic logic [DW-1:0] readPort(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] stored,
    input logic          rdN,
    input logic          wrEn,
    input logic [AW-1:0] wrAddr,
    input logic [DW-1:0] wrData
  );
    logic [DW-1:0] value;
    value = '0;
    if (!rdN && (addr != '0)) begin
      if (wrEn && (addr == wrAddr)) value = wrData;
      else                          value = stored;
    end
    return value;
  endfunction

  assign rfWrEn    = !REG_WR && (DIR_WRA != '0);
  assign out_valid = (state_q == FULL);
  assign in_ready  = (!out_valid || out_ready) && !flush;
  assign capture   = in_valid && in_ready;
  assign jmpTarget = {pc_4, address, 2'b00};

  // Operand reads and immediate extension feeding the output register.
  always_comb begin
    readA  = readPort(DIR_A, regs_q[DIR_A], REG_RD, rfWrEn, DIR_WRA, DI);
    readB  = readPort(DIR_B, regs_q[DIR_B], REG_RD, rfWrEn, DIR_WRA, DI);
    extImm = SEL_I ? DW'($signed(IMD)) : DW'(IMD);
  end

  // Register file: writes ignore the handshake entirely; r0 is never written.
  always_ff @(posedge reloj or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rfWrEn) begin
      regs_q[DIR_WRA] <= DI;
    end
  end

  // Output-stage occupancy: flush empties it, capture fills it, a consumer
  // accept without a new capture drains it.
  always_comb begin
    state_d = state_q;
    if (flush)                            state_d = EMPTY;
    else if (capture)                     state_d = FULL;
    else if (state_q == FULL && out_ready) state_d = EMPTY;
  end

  // State register for the output stage.
  always_ff @(posedge reloj or negedge resetn) begin
    if (!resetn) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Data outputs load only on capture, so a stalled stage holds its values
  // even if the register file entries behind them are rewritten.
  always_ff @(posedge reloj or negedge resetn) begin
    if (!resetn) begin
      doa_q <= '0;
      dob_q <= '0;
      imm_q <= '0;
      jmp_q <= '0;
    end else if (capture) begin
      doa_q <= readA;
      dob_q <= readB;
      imm_q <= extImm;
      jmp_q <= jmpTarget;
    end
  end

  assign DOA        = doa_q;
  assign DOB        = dob_q;
  assign out_mux_sz = imm_q;
  assign out_addr   = jmp_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe with hand-computed expectations.
module tb_decode_pipe;

  logic        reloj;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  DIR_A, DIR_B, DIR_WRA;
  logic [31:0] DI;
  logic        REG_RD, REG_WR, SEL_I;
  logic [15:0] IMD;
  logic [25:0] address;
  logic [3:0]  pc_4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] DOA, DOB, out_mux_sz, out_addr;

  int checkCount = 0;
  int errorCount = 0;

  decode_pipe dut (
    .reloj      (reloj),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .DIR_A      (DIR_A),
    .DIR_B      (DIR_B),
    .DIR_WRA    (DIR_WRA),
    .DI         (DI),
    .REG_RD     (REG_RD),
    .REG_WR     (REG_WR),
    .SEL_I      (SEL_I),
    .IMD        (IMD),
    .address    (address),
    .pc_4       (pc_4),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .DOA        (DOA),
    .DOB        (DOB),
    .out_mux_sz (out_mux_sz),
    .out_addr   (out_addr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic stepClk();
    @(posedge reloj);
    #1;
  endtask

  // Main directed sequence.
  initial begin
    resetn = 1'b0; in_valid = 1'b0; DIR_A = '0; DIR_B = '0; DIR_WRA = '0;
    DI = '0; REG_RD = 1'b1; REG_WR = 1'b1; SEL_I = 1'b0; IMD = '0;
    address = '0; pc_4 = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #1;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_doa", DOA, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    #11 resetn = 1'b1;

    // Write r5, then read it back through a capture
    REG_WR = 1'b0; DIR_WRA = 5'd5; DI = 32'hDEADBEEF;
    stepClk();
    checkOutput("s1_no_capture", {31'd0, out_valid}, 32'd0);
    REG_WR = 1'b1; DIR_A = 5'd5; DIR_B = 5'd0; REG_RD = 1'b0; in_valid = 1'b1;
    stepClk();
    checkOutput("s1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("s1_doa", DOA, 32'hDEADBEEF);
    checkOutput("s1_dob", DOB, 32'd0);
    in_valid = 1'b0;
    stepClk();
    checkOutput("s1_drain", {31'd0, out_valid}, 32'd0);

    // Same-cycle write and read of r7 through both ports
    REG_WR = 1'b0; DIR_WRA = 5'd7; DI = 32'h12345678;
    DIR_A = 5'd7; DIR_B = 5'd7; in_valid = 1'b1;
    stepClk();
    checkOutput("s2_bypass_a", DOA, 32'h12345678);
    checkOutput("s2_bypass_b", DOB, 32'h12345678);
    // Write attempt to r0 with read of r0
    DIR_WRA = 5'd0; DI = 32'hFFFFFFFF; DIR_A = 5'd0; DIR_B = 5'd7;
    stepClk();
    checkOutput("s2_r0_bypass", DOA, 32'd0);
    checkOutput("s2_r7_stored", DOB, 32'h12345678);
    REG_WR = 1'b1;
    stepClk();
    checkOutput("s2_r0_stored", DOA, 32'd0);

    // Immediate extension and jump target
    IMD = 16'h8001; SEL_I = 1'b1; pc_4 = 4'hA; address = 26'h3FFFFFF;
    stepClk();
    checkOutput("s3_sext", out_mux_sz, 32'hFFFF8001);
    checkOutput("s3_jump", out_addr, 32'hAFFFFFFC);
    SEL_I = 1'b0; pc_4 = 4'h1; address = 26'h0000003;
    stepClk();
    checkOutput("s3_zext", out_mux_sz, 32'h00008001);
    checkOutput("s3_jump2", out_addr, 32'h1000000C);

    // Stall: out_ready low while r5 is rewritten
    DIR_A = 5'd5; DIR_B = 5'd0;
    stepClk();
    checkOutput("s4_pre_doa", DOA, 32'hDEADBEEF);
    out_ready = 1'b0; REG_WR = 1'b0; DIR_WRA = 5'd5; DI = 32'h55555555;
    DIR_A = 5'd7; SEL_I = 1'b1;
    #1;
    checkOutput("s4_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("s4_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("s4_hold_doa", DOA, 32'hDEADBEEF);
      checkOutput("s4_hold_imm", out_mux_sz, 32'h00008001);
    end
    REG_WR = 1'b1; out_ready = 1'b1; DIR_A = 5'd5;
    #1;
    checkOutput("s4_ready_high", {31'd0, in_ready}, 32'd1);
    stepClk();
    checkOutput("s4_b2b_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("s4_b2b_doa", DOA, 32'h55555555);
    checkOutput("s4_b2b_imm", out_mux_sz, 32'hFFFF8001);

    // Flush beats a simultaneous request
    flush = 1'b1; DIR_A = 5'd7;
    #1;
    checkOutput("s5_ready_flush", {31'd0, in_ready}, 32'd0);
    stepClk();
    checkOutput("s5_flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; REG_RD = 1'b1; DIR_A = 5'd5; DIR_B = 5'd7;
    stepClk();
    checkOutput("s5_rd_off_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("s5_rd_off_doa", DOA, 32'd0);
    checkOutput("s5_rd_off_dob", DOB, 32'd0);

    // Asynchronous reset in the middle of a stall
    REG_RD = 1'b0; DIR_A = 5'd5; DIR_B = 5'd7; pc_4 = 4'hA; address = 26'h3FFFFFF;
    stepClk();
    checkOutput("s6_pre_doa", DOA, 32'h55555555);
    out_ready = 1'b0;
    stepClk();
    #2 resetn = 1'b0;
    #1;
    checkOutput("s6_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("s6_rst_doa", DOA, 32'd0);
    checkOutput("s6_rst_dob", DOB, 32'd0);
    checkOutput("s6_rst_imm", out_mux_sz, 32'd0);
    checkOutput("s6_rst_jump", out_addr, 32'd0);
    #2 resetn = 1'b1;
    #1;
    checkOutput("s6_rel_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    stepClk();
    checkOutput("s6_read_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("s6_read_r5", DOA, 32'd0);
    checkOutput("s6_read_r7", DOB, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
